// File: rtl/tiny_cpu_fetch.sv
// Instruction store and sequencer that feeds tiny_cpu's ui_in byte (opcode = [7:4], imm = [3:0]).
// Optional feature: define TINY_FETCH_LOOP_EN to wrap pc to 0 at end of program instead of halting.
module tiny_cpu_fetch #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load_en,
   input  logic          load_valid,
   input  logic [7:0]    load_data,
   output logic          load_ready,
   input  logic          start,
   input  logic          stop,
   output logic [7:0]    instr,
   output logic          instr_valid,
   output logic [AW-1:0] pc,
   output logic          busy,
   output logic          done
);
   typedef enum logic [1:0] {IDLE, LOAD, RUN, HALT} state_t;

   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE  = (AW+1)'(1);

   state_t        state, state_nx;
   logic [7:0]    mem [DEPTH];
   logic [AW:0]   wr_cnt, wr_cnt_nx, prog_len, prog_len_nx, last_idx;
   logic [7:0]    instr_nx, fetch_data;
   logic          instr_valid_nx, wr_fire, at_last, launch, fetch_halt;
   logic [AW-1:0] pc_nx, fetch_addr;

   assign load_ready = (state == LOAD) && (wr_cnt < FULL);
   assign wr_fire    = load_ready && load_valid;
   assign busy       = (state == RUN);
   assign done       = (state == HALT);
   assign last_idx   = prog_len - ONE;
   assign at_last    = ({1'b0, pc} == last_idx);

   // Next slot to present; a fresh start and the end-of-program wrap both fetch slot 0.
   assign fetch_addr = (state == RUN && !at_last) ? pc + 1'b1 : '0;
   assign fetch_data = mem[fetch_addr];
   assign fetch_halt = (fetch_data[7:4] == 4'hF);

   always_ff @(posedge clk) begin
      if (wr_fire) begin
         mem[wr_cnt[AW-1:0]] <= load_data;
      end
   end

   always_comb begin
      state_nx       = state;
      wr_cnt_nx      = wr_cnt;
      prog_len_nx    = prog_len;
      instr_nx       = instr;
      pc_nx          = pc;
      instr_valid_nx = 1'b0;
      launch         = 1'b0;

      case (state)
         IDLE, HALT: begin
            if (load_en) begin
               state_nx  = LOAD;
               wr_cnt_nx = '0;
            end else if (start && prog_len != '0) begin
               launch = 1'b1;
            end
         end
         LOAD: begin
            if (wr_fire) begin
               wr_cnt_nx = wr_cnt + ONE;
            end
            if (!load_en) begin
               state_nx    = IDLE;
               prog_len_nx = wr_fire ? wr_cnt + ONE : wr_cnt;
            end
         end
         RUN: begin
            if (stop) begin
               state_nx = HALT;
            end else if (at_last) begin
`ifdef TINY_FETCH_LOOP_EN
               launch = 1'b1;
`else
               state_nx = HALT;
`endif
            end else begin
               launch = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase

      // A HALT opcode is swallowed: instr/pc keep the last issued instruction.
      if (launch) begin
         if (fetch_halt) begin
            state_nx = HALT;
         end else begin
            state_nx       = RUN;
            instr_nx       = fetch_data;
            pc_nx          = fetch_addr;
            instr_valid_nx = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         instr       <= 8'h00;
         instr_valid <= 1'b0;
         pc          <= '0;
         wr_cnt      <= '0;
         prog_len    <= '0;
      end else begin
         state       <= state_nx;
         instr       <= instr_nx;
         instr_valid <= instr_valid_nx;
         pc          <= pc_nx;
         wr_cnt      <= wr_cnt_nx;
         prog_len    <= prog_len_nx;
      end
   end
endmodule
